// File: rtl/sr_pkg.sv
// Shared types and default constants for the sr_ff command generator.
package sr_pkg;

  // Command FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    LOCKOUT = 2'd2
  } sr_state_e;

  // Default cycle counts and counter width
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int LOCKOUT_CYCLES_DEF  = 2;
  localparam int CNT_W_DEF           = 8;

endpackage : sr_pkg

// File: rtl/sr_cmd_gen_if.sv
// Command-side bundle between the request source and sr_cmd_gen:
// raw requests, enable and q feedback in; s/r pulses and status out.
interface sr_cmd_gen_if;

  logic set_raw;       // raw set request level (asynchronous)
  logic clr_raw;       // raw clear request level (asynchronous)
  logic en;            // command enable
  logic q_fb;          // current q of the downstream sr_ff
  logic s_out;         // set pulse to sr_ff s
  logic r_out;         // reset pulse to sr_ff r
  logic busy;          // high while a command is being issued or locked out
  logic conflict_err;  // sticky set/clear coincidence flag

  // Request source side
  modport master (
    output set_raw, clr_raw, en, q_fb,
    input  s_out, r_out, busy, conflict_err
  );

  // sr_cmd_gen side
  modport slave (
    input  set_raw, clr_raw, en, q_fb,
    output s_out, r_out, busy, conflict_err
  );

endinterface : sr_cmd_gen_if

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchroniser, debounce filter and a
// single-cycle request on each rising edge of the filtered level.
module sr_debounce
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic req_o
);

  // Counter value on the last of DEBOUNCE_CYCLES consecutive differing samples
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchroniser for the asynchronous raw level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so sync2_q takes the old sync1_q; blocking would collapse both stages into one flop.
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Filter: the level follows the synchronised input only after it has
  // differed for DEBOUNCE_CYCLES consecutive samples
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state and delayed level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  // Falling edges of the filtered level produce no request
  assign req_o = level_q & ~level_dly_q;

endmodule : sr_debounce

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear requests into clean, mutually exclusive,
// single-cycle s/r pulses for sr_ff, suppressing redundant commands
// using q feedback and spacing commands with a lockout window.
module sr_cmd_gen
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  sr_cmd_gen_if.slave  bus
);

  // Lockout counter value on the final lockout cycle (unused when LOCKOUT_CYCLES=0)
  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);

  logic             req_set, req_clr;
  logic             req_set_v, req_clr_v;
  logic             cand_set, cand_clr;
  logic             do_set, do_clr;
  sr_state_e        state_q, state_d;
  logic             pend_set_q, pend_set_d;
  logic             pend_clr_q, pend_clr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             conflict_q, conflict_d;
  logic             s_out_q, s_out_d;
  logic             r_out_q, r_out_d;
  logic             busy_q, busy_d;

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .raw_i (bus.set_raw),
    .req_o (req_set)
  );

  sr_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_clr (
    .clk   (clk),
    .rst   (rst),
    .raw_i (bus.clr_raw),
    .req_o (req_clr)
  );

  // Requests arriving while disabled are discarded outright
  assign req_set_v = req_set & bus.en;
  assign req_clr_v = req_clr & bus.en;

  // State, pending, lockout, conflict and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      lock_cnt_q <= '0;
      conflict_q <= 1'b0;
      s_out_q    <= 1'b0;
      r_out_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      lock_cnt_q <= lock_cnt_d;
      conflict_q <= conflict_d;
      s_out_q    <= s_out_d;
      r_out_q    <= r_out_d;
      busy_q     <= busy_d;
    end
  end

  // Next state: arbitrate candidates in IDLE, otherwise absorb requests
  // into the one-deep pending bits until the lockout window closes
  always_comb begin
    state_d    = state_q;
    pend_set_d = pend_set_q & bus.en;
    pend_clr_d = pend_clr_q & bus.en;
    lock_cnt_d = '0;
    conflict_d = conflict_q | (req_set_v & req_clr_v);
    cand_set   = 1'b0;
    cand_clr   = 1'b0;
    do_set     = 1'b0;
    do_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cand_set = req_set_v | pend_set_d;
        cand_clr = req_clr_v | pend_clr_d;
        // Every candidate is resolved here: issued, redundant or discarded
        pend_set_d = 1'b0;
        pend_clr_d = 1'b0;
        // Clear wins a coincidence; the set candidate is thrown away
        if (cand_set && cand_clr) begin
          conflict_d = 1'b1;
          cand_set   = 1'b0;
        end
        if (cand_clr && bus.q_fb) begin
          do_clr = 1'b1;
        end else if (cand_set && !bus.q_fb) begin
          do_set = 1'b1;
        end
        if (do_set || do_clr) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        pend_set_d = pend_set_d | req_set_v;
        pend_clr_d = pend_clr_d | req_clr_v;
        state_d    = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
      end

      LOCKOUT: begin
        pend_set_d = pend_set_d | req_set_v;
        pend_clr_d = pend_clr_d | req_clr_v;
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs for the next cycle: a pulse only on entry to ISSUE
  always_comb begin
    s_out_d = do_set;
    r_out_d = do_clr;
    busy_d  = (state_d != IDLE);
  end

  assign bus.s_out        = s_out_q;
  assign bus.r_out        = r_out_q;
  assign bus.busy         = busy_q;
  assign bus.conflict_err = conflict_q;

endmodule : sr_cmd_gen

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: directed scenarios with fixed
// latency expectations plus a long randomized run, all compared every
// cycle against a behavioural model of the command rules.
module tb_sr_cmd_gen;
  import sr_pkg::*;

  localparam int DB = DEBOUNCE_CYCLES_DEF;
  localparam int LK = LOCKOUT_CYCLES_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Pulse tallies for the directed scenarios
  int s_cnt, r_cnt, busy_cnt, first_s, first_r;

  sr_cmd_gen_if bus ();

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES (DB),
    .LOCKOUT_CYCLES  (LK),
    .CNT_W           (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------
  // Behavioural model. Channel 0 = set, channel 1 = clear.
  // The filter is a window: the level flips once the last DB
  // synchronised samples all disagree with it.
  // ---------------------------------------------------------------
  logic [1:0]    m_dly  [2];  // raw samples of the last two edges
  logic [DB-1:0] m_hist [2];  // most recent synchronised samples
  logic          m_filt [2];
  logic          m_req  [2];  // request visible in the current cycle
  logic          m_pend [2];
  logic          m_busy, m_s, m_r, m_conf;
  int            m_rem;       // lockout cycles still owed after the current one

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_dly[ch]  = '0;
      m_hist[ch] = '0;
      m_filt[ch] = 1'b0;
      m_req[ch]  = 1'b0;
      m_pend[ch] = 1'b0;
    end
    m_busy = 1'b0;
    m_s    = 1'b0;
    m_r    = 1'b0;
    m_conf = 1'b0;
    m_rem  = 0;
  endtask

  // Advance the model across one clock edge with the inputs sampled there
  task automatic model_edge(input logic raw_s, input logic raw_c, input logic e, input logic q);
    logic       rs, rc, cs, cc, ns, nr, nb, synced;
    logic [1:0] raw;
    raw = {raw_c, raw_s};
    rs  = m_req[0] & e;
    rc  = m_req[1] & e;
    if (!e) begin
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
    end
    if (rs && rc) m_conf = 1'b1;
    ns = 1'b0;
    nr = 1'b0;
    if (m_busy) begin
      m_pend[0] = m_pend[0] | rs;
      m_pend[1] = m_pend[1] | rc;
      if (m_rem > 0) begin
        m_rem--;
        nb = 1'b1;
      end else begin
        nb = 1'b0;
      end
    end else begin
      cs = rs | m_pend[0];
      cc = rc | m_pend[1];
      if (cs && cc) begin
        m_conf = 1'b1;
        cs     = 1'b0;
      end
      if (cc && q)       nr = 1'b1;
      else if (cs && !q) ns = 1'b1;
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
      nb = ns | nr;
      if (nb) m_rem = LK;
    end
    m_s    = ns;
    m_r    = nr;
    m_busy = nb;

    for (int ch = 0; ch < 2; ch++) begin
      synced     = m_dly[ch][1];
      m_dly[ch]  = {m_dly[ch][0], raw[ch]};
      m_hist[ch] = (m_hist[ch] << 1) | DB'(synced);
      m_req[ch]  = 1'b0;
      if (m_hist[ch] == {DB{~m_filt[ch]}}) begin
        m_filt[ch] = ~m_filt[ch];
        m_req[ch]  = m_filt[ch];
      end
    end
  endtask

  // One clock: capture inputs at the edge, compare outputs on the falling edge
  task automatic step(input int idx);
    logic rs, rc, e, q;
    @(posedge clk);
    rs = bus.set_raw;
    rc = bus.clr_raw;
    e  = bus.en;
    q  = bus.q_fb;
    @(negedge clk);
    model_edge(rs, rc, e, q);
    check("s_out",        bus.s_out,        m_s);
    check("r_out",        bus.r_out,        m_r);
    check("busy",         bus.busy,         m_busy);
    check("conflict_err", bus.conflict_err, m_conf);
    if (bus.s_out === 1'b1) begin
      s_cnt++;
      if (first_s < 0) first_s = idx;
    end
    if (bus.r_out === 1'b1) begin
      r_cnt++;
      if (first_r < 0) first_r = idx;
    end
    if (bus.busy === 1'b1) busy_cnt++;
  endtask

  task automatic clear_tally();
    s_cnt    = 0;
    r_cnt    = 0;
    busy_cnt = 0;
    first_s  = -1;
    first_r  = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(i);
  endtask

  // Drop both raw inputs and let filters and lockout drain
  task automatic settle();
    bus.set_raw = 1'b0;
    bus.clr_raw = 1'b0;
    run(14);
  endtask

  // Reset pulse; the edge after release is edge 0 of the next scenario
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_s_out",    bus.s_out,        1'b0);
    check("rst_r_out",    bus.r_out,        1'b0);
    check("rst_busy",     bus.busy,         1'b0);
    check("rst_conflict", bus.conflict_err, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    bus.set_raw = 1'b0;
    bus.clr_raw = 1'b0;
    bus.en      = 1'b1;
    bus.q_fb    = 1'b0;
    model_reset();
    clear_tally();
    do_reset();

    // Basic set: pulse after edge 2+DB, busy for ISSUE plus lockout
    bus.set_raw = 1'b1;
    clear_tally();
    run(20);
    check("set_first_edge", first_s, 2 + DB);
    check("set_pulses",     s_cnt,   1);
    check("set_busy_len",   busy_cnt, 1 + LK);
    check("set_no_r",       r_cnt,   0);
    settle();

    // Bounce: single-cycle glitches never pass the filter
    clear_tally();
    for (int b = 0; b < 4; b++) begin
      bus.set_raw = (b % 2 == 0);
      step(b);
    end
    check("bounce_quiet", s_cnt, 0);
    bus.set_raw = 1'b1;
    clear_tally();
    run(20);
    check("bounce_first_edge", first_s, 2 + DB);
    check("bounce_pulses",     s_cnt,   1);
    settle();

    // Simultaneous set and clear with q=1: clear wins, conflict latched
    bus.q_fb    = 1'b1;
    bus.set_raw = 1'b1;
    bus.clr_raw = 1'b1;
    clear_tally();
    run(20);
    check("simul_first_r", first_r, 2 + DB);
    check("simul_r_pulses", r_cnt, 1);
    check("simul_no_s",     s_cnt, 0);
    check("simul_conflict", bus.conflict_err, 1'b1);
    settle();
    check("conflict_sticky", bus.conflict_err, 1'b1);

    // Redundant set while q=1, then a real set with q=0
    bus.set_raw = 1'b1;
    clear_tally();
    run(16);
    check("redundant_no_s",    s_cnt,    0);
    check("redundant_no_busy", busy_cnt, 0);
    settle();
    bus.q_fb    = 1'b0;
    bus.set_raw = 1'b1;
    clear_tally();
    run(20);
    check("fresh_set_first", first_s, 2 + DB);
    check("fresh_set_pulses", s_cnt, 1);
    settle();

    // Clear request lands during lockout, q flips after ISSUE
    bus.q_fb    = 1'b0;
    bus.set_raw = 1'b1;
    clear_tally();
    for (int i = 0; i < 25; i++) begin
      step(i);
      if (i == 1) bus.clr_raw = 1'b1;
      if (i == 7) bus.q_fb    = 1'b1;
    end
    check("pend_set_first", first_s, 2 + DB);
    check("pend_r_first",   first_r, 2 + DB + 2 + LK);
    check("pend_r_pulses",  r_cnt,   1);
    bus.q_fb = 1'b0;
    settle();

    // Same sequence with en dropped while the clear is pending
    bus.set_raw = 1'b1;
    clear_tally();
    for (int i = 0; i < 25; i++) begin
      step(i);
      if (i == 1)  bus.clr_raw = 1'b1;
      if (i == 7)  bus.q_fb    = 1'b1;
      if (i == 8)  bus.en      = 1'b0;
      if (i == 12) bus.en      = 1'b1;
    end
    check("en_set_first", first_s, 2 + DB);
    check("en_no_r",      r_cnt,   0);
    bus.q_fb = 1'b0;
    settle();

    // Reset in ISSUE with set held: pulse drops at once, one fresh pulse after
    bus.set_raw = 1'b1;
    clear_tally();
    run(2 + DB + 1);
    check("pre_rst_s_out", bus.s_out, 1'b1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_s_out", bus.s_out, 1'b0);
    check("async_rst_busy",  bus.busy,  1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_tally();
    run(20);
    check("post_rst_first",  first_s, 2 + DB);
    check("post_rst_pulses", s_cnt,   1);
    check("post_rst_conflict", bus.conflict_err, 1'b0);
    settle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(i);
      if ($urandom_range(5) == 0) bus.set_raw = ~bus.set_raw;
      if ($urandom_range(5) == 0) bus.clr_raw = ~bus.clr_raw;
      bus.en = ($urandom_range(15) != 0);
      if ($urandom_range(9) == 0) bus.q_fb = ~bus.q_fb;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sr_cmd_gen
